ctrl_sequencer: RTL and testbench

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/ctrl_sequencer_if.sv | 31 +++
 rtl/ctrl_sequencer.sv | 150 +++++++++++++++
 tb/tb_ctrl_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_sequencer_if.sv
// Sequencer bus: run request, program memory read, ALU status and all control strobes.
// The sequencer side uses the master modport; memory/datapath/bench use the slave modport.
interface ctrl_sequencer_if;
  logic       run;
  logic [7:0] prog_mem_data;
  logic       alu_zero;
  logic [4:0] prog_cnt;
  logic [3:0] instr_code;
  logic       load_en;
  logic       store_en;
  logic       R0_ce;
  logic       R1_ce;
  logic       R0_oe;
  logic       R1_oe;
  logic       acu_ce;
  logic [2:0] alu_op;
  logic       halted;
  logic       illegal;

  modport master (
    input  run, prog_mem_data, alu_zero,
    output prog_cnt, instr_code, load_en, store_en, R0_ce, R1_ce, R0_oe, R1_oe,
           acu_ce, alu_op, halted, illegal
  );

  modport slave (
    output run, prog_mem_data, alu_zero,
    input  prog_cnt, instr_code, load_en, store_en, R0_ce, R1_ce, R0_oe, R1_oe,
           acu_ce, alu_op, halted, illegal
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute control sequencer for an 8-bit accumulator datapath.
// Strobes are registered: they are computed on the DECODE->EXEC transition so they are valid for exactly the EXEC cycle.
module ctrl_sequencer (
  input  logic             clk,
  input  logic             rst,
  ctrl_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_TARGET = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef struct packed {
    logic       load_en;
    logic       store_en;
    logic       r0_ce;
    logic       r1_ce;
    logic       r0_oe;
    logic       r1_oe;
    logic       acu_ce;
    logic [2:0] alu_op;
    logic       illegal;
    logic       halted;
  } out_t;

  state_e     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  // Only the opcode nibble and the register-select bit of the instruction are ever used.
  logic [4:0] ir_q, ir_d;
  logic       zflag_q, zflag_d;
  out_t       out_q, out_d;

  logic [3:0] op_s;
  logic       rsel_s;
  logic       is_alu_s;

  assign op_s     = ir_q[4:1];
  assign rsel_s   = ir_q[0];
  assign is_alu_s = (op_s >= 4'h4) && (op_s <= 4'h8);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    zflag_d = zflag_q;
    out_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
        else         state_d = S_IDLE;
      end
      S_FETCH: begin
        ir_d    = {bus.prog_mem_data[7:4], bus.prog_mem_data[0]};
        pc_d    = pc_q + 5'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXEC;
        case (op_s)
          4'h1: begin
            out_d.load_en = 1'b1;
            if (rsel_s) out_d.r1_ce = 1'b1;
            else        out_d.r0_ce = 1'b1;
          end
          4'h2: begin
            out_d.store_en = 1'b1;
            if (rsel_s) out_d.r1_oe = 1'b1;
            else        out_d.r0_oe = 1'b1;
          end
          4'h3: begin
            if (rsel_s) out_d.r1_ce = 1'b1;
            else        out_d.r0_ce = 1'b1;
          end
          4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
            out_d.r0_oe  = 1'b1;
            out_d.r1_oe  = 1'b1;
            out_d.acu_ce = 1'b1;
            case (op_s)
              4'h5:    out_d.alu_op = 3'd1;
              4'h6:    out_d.alu_op = 3'd2;
              4'h7:    out_d.alu_op = 3'd3;
              4'h8:    out_d.alu_op = 3'd4;
              default: out_d.alu_op = 3'd0;
            endcase
          end
          4'hB, 4'hC, 4'hD, 4'hE: out_d.illegal = 1'b1;
          default: out_d = '0;
        endcase
      end
      S_EXEC: begin
        if (is_alu_s) zflag_d = bus.alu_zero;
        else          zflag_d = zflag_q;
        case (op_s)
          4'h9, 4'hA: state_d = S_TARGET;
          4'hF: begin
            state_d      = S_HALT;
            out_d.halted = 1'b1;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_TARGET: begin
        // Not-taken JZ steps over the operand byte that prog_cnt currently addresses.
        if ((op_s == 4'h9) || zflag_q) pc_d = bus.prog_mem_data[4:0];
        else                           pc_d = pc_q + 5'd1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d      = S_HALT;
        out_d.halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= 5'd0;
      ir_q    <= 5'd0;
      zflag_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zflag_q <= zflag_d;
      out_q   <= out_d;
    end
  end

  assign bus.prog_cnt   = pc_q;
  assign bus.instr_code = ir_q[4:1];
  assign bus.load_en    = out_q.load_en;
  assign bus.store_en   = out_q.store_en;
  assign bus.R0_ce      = out_q.r0_ce;
  assign bus.R1_ce      = out_q.r1_ce;
  assign bus.R0_oe      = out_q.r0_oe;
  assign bus.R1_oe      = out_q.r1_oe;
  assign bus.acu_ce     = out_q.acu_ce;
  assign bus.alu_op     = out_q.alu_op;
  assign bus.illegal    = out_q.illegal;
  assign bus.halted     = out_q.halted;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: per-opcode vector table through a scoreboard,
// then hand-written branch, wrap, halt/illegal and asynchronous-reset sequences.
module tb_ctrl_sequencer;

  logic clk;
  logic rst;
  logic run_r;
  logic alu_zero_r;
  logic [7:0] mem [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctrl_sequencer_if bus ();

  assign bus.run           = run_r;
  assign bus.alu_zero      = alu_zero_r;
  assign bus.prog_mem_data = mem[bus.prog_cnt];

  ctrl_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0] pc;
    logic [3:0] code;
    logic [6:0] strb;  // load, store, R0_ce, R1_ce, R0_oe, R1_oe, acu_ce
    logic [2:0] alu;
    logic       ill;
    logic       hlt;
  } obs_t;

  typedef struct {
    logic [7:0] opc;
    logic [6:0] strb;
    logic [2:0] alu;
    logic       ill;
    logic       hlt;
    logic [4:0] pc5;
    logic [3:0] code5;
  } vec_t;

  obs_t exp_q [$];
  vec_t vt [16];
  int   checks = 0;
  int   errors = 0;
  int   ill_cnt = 0;

  function automatic obs_t mk(input logic [4:0] pc, input logic [3:0] code, input logic [6:0] strb,
                              input logic [2:0] alu, input logic ill, input logic hlt);
    obs_t o;
    o.pc = pc; o.code = code; o.strb = strb; o.alu = alu; o.ill = ill; o.hlt = hlt;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(bus.prog_cnt, bus.instr_code,
              {bus.load_en, bus.store_en, bus.R0_ce, bus.R1_ce, bus.R0_oe, bus.R1_oe, bus.acu_ce},
              bus.alu_op, bus.illegal, bus.halted);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t a, input obs_t x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got pc=%0d code=%h strb=%b alu=%0d ill=%b hlt=%b, expected pc=%0d code=%h strb=%b alu=%0d ill=%b hlt=%b",
               name, a.pc, a.code, a.strb, a.alu, a.ill, a.hlt, x.pc, x.code, x.strb, x.alu, x.ill, x.hlt);
    end
  endtask

  // One clock with an expected observation queued before the edge and checked after it.
  task automatic tick_exp(input obs_t e, input string name);
    obs_t x;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk_obs(name, sample(), x);
    if (bus.illegal) ill_cnt++;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (bus.illegal) ill_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    run_r      = 1'b0;
    alu_zero_r = 1'b0;
    rst        = 1'b1;
    for (int a = 0; a < 32; a++) mem[a] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] op;
    rst        = 1'b0;
    run_r      = 1'b0;
    alu_zero_r = 1'b0;
    for (int a = 0; a < 32; a++) mem[a] = 8'h00;

    vt[0]  = '{8'h00, 7'b0000000, 3'd0, 1'b0, 1'b0, 5'd2,  4'h1};
    vt[1]  = '{8'h10, 7'b1010000, 3'd0, 1'b0, 1'b0, 5'd2,  4'h1};
    vt[2]  = '{8'h11, 7'b1001000, 3'd0, 1'b0, 1'b0, 5'd2,  4'h1};
    vt[3]  = '{8'h20, 7'b0100100, 3'd0, 1'b0, 1'b0, 5'd2,  4'h1};
    vt[4]  = '{8'h21, 7'b0100010, 3'd0, 1'b0, 1'b0, 5'd2,  4'h1};
    vt[5]  = '{8'h30, 7'b0010000, 3'd0, 1'b0, 1'b0, 5'd2,  4'h1};
    vt[6]  = '{8'h31, 7'b0001000, 3'd0, 1'b0, 1'b0, 5'd2,  4'h1};
    vt[7]  = '{8'h40, 7'b0000111, 3'd0, 1'b0, 1'b0, 5'd2,  4'h1};
    vt[8]  = '{8'h51, 7'b0000111, 3'd1, 1'b0, 1'b0, 5'd2,  4'h1};
    vt[9]  = '{8'h60, 7'b0000111, 3'd2, 1'b0, 1'b0, 5'd2,  4'h1};
    vt[10] = '{8'h70, 7'b0000111, 3'd3, 1'b0, 1'b0, 5'd2,  4'h1};
    vt[11] = '{8'h80, 7'b0000111, 3'd4, 1'b0, 1'b0, 5'd2,  4'h1};
    vt[12] = '{8'h9F, 7'b0000000, 3'd0, 1'b0, 1'b0, 5'd28, 4'h9};
    vt[13] = '{8'hA0, 7'b0000000, 3'd0, 1'b0, 1'b0, 5'd2,  4'hA};
    vt[14] = '{8'hB0, 7'b0000000, 3'd0, 1'b1, 1'b0, 5'd2,  4'h1};
    vt[15] = '{8'hF0, 7'b0000000, 3'd0, 1'b0, 1'b1, 5'd1,  4'hF};

    // Power-on reset state, checked while rst is still held.
    #2 rst = 1'b1;
    #1 chk_obs("reset_state", sample(), mk(5'd0, 4'h0, 7'b0, 3'd0, 1'b0, 1'b0));

    // Single-instruction programs from reset; mem[1] = 0x1C serves as a branch operand.
    for (int i = 0; i < 16; i++) begin
      do_reset();
      mem[0] = vt[i].opc;
      mem[1] = 8'h1C;
      run_r  = 1'b1;
      op     = vt[i].opc[7:4];
      tick_exp(mk(5'd0, 4'h0, 7'b0, 3'd0, 1'b0, 1'b0), $sformatf("v%0d_fetch", i));
      tick_exp(mk(5'd1, op, 7'b0, 3'd0, 1'b0, 1'b0), $sformatf("v%0d_decode", i));
      tick_exp(mk(5'd1, op, vt[i].strb, vt[i].alu, vt[i].ill, 1'b0), $sformatf("v%0d_exec", i));
      tick_exp(mk(5'd1, op, 7'b0, 3'd0, 1'b0, vt[i].hlt), $sformatf("v%0d_post1", i));
      tick_exp(mk(vt[i].pc5, vt[i].code5, 7'b0, 3'd0, 1'b0, vt[i].hlt), $sformatf("v%0d_post2", i));
    end

    // SUB sets zflag, JZ taken.
    do_reset();
    mem[0] = 8'h50; mem[1] = 8'hA0; mem[2] = 8'h1C;
    alu_zero_r = 1'b1; run_r = 1'b1;
    step(8);
    chk("jz_taken_pc", bus.prog_cnt, 28);

    // SUB clears zflag, JZ falls through past its operand.
    do_reset();
    mem[0] = 8'h50; mem[1] = 8'hA0; mem[2] = 8'h1C;
    alu_zero_r = 1'b0; run_r = 1'b1;
    step(8);
    chk("jz_not_taken_pc", bus.prog_cnt, 3);

    // LOAD between SUB and JZ must not disturb zflag.
    do_reset();
    mem[0] = 8'h50; mem[1] = 8'h10; mem[2] = 8'hA0; mem[3] = 8'h1D;
    alu_zero_r = 1'b1; run_r = 1'b1;
    step(4);
    alu_zero_r = 1'b0;
    step(7);
    chk("zflag_hold_pc", bus.prog_cnt, 29);

    // JMP to 31, whose FETCH wraps prog_cnt to 0.
    do_reset();
    mem[0] = 8'h90; mem[1] = 8'h1F;
    run_r = 1'b1;
    step(5);
    chk("jmp31_pc", bus.prog_cnt, 31);
    step(1);
    chk("wrap_pc", bus.prog_cnt, 0);

    // Illegal opcode then HALT; run toggling must not wake it.
    do_reset();
    mem[0] = 8'hC0; mem[1] = 8'hF0;
    run_r = 1'b1;
    ill_cnt = 0;
    step(7);
    chk("halt_entered", bus.halted, 1);
    chk("halt_pc", bus.prog_cnt, 2);
    for (int c = 0; c < 20; c++) begin
      run_r = ~run_r;
      step(1);
      chk($sformatf("halt_hold_%0d", c), {bus.halted, bus.prog_cnt}, {1'b1, 5'd2});
    end
    chk("illegal_pulse_count", ill_cnt, 1);

    // Asynchronous reset in the middle of a STORE EXEC cycle.
    do_reset();
    mem[0] = 8'h20;
    run_r = 1'b1;
    step(3);
    chk("store_exec", {bus.store_en, bus.R0_oe}, 2'b11);
    #2 rst = 1'b1;
    #1 chk_obs("async_rst_outputs", sample(), mk(5'd0, 4'h0, 7'b0, 3'd0, 1'b0, 1'b0));
    run_r = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(5);
    chk_obs("idle_after_rst", sample(), mk(5'd0, 4'h0, 7'b0, 3'd0, 1'b0, 1'b0));
    run_r = 1'b1;
    step(2);
    chk("refetch_addr0", {bus.prog_cnt, bus.instr_code}, {5'd1, 4'h2});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
